datapath_sequencer: RTL and testbench

- Micro-sequencer directly upstream of the datapath.
- Holds a small program memory, fetches one instruction at a time and drives the datapath control inputs: Sel, Wen, WA, RAA, RAB, Op.
- Consumes the datapath's Flag output to resolve conditional branches.
- Its outputs connect one-to-one to the same-named datapath ports.

---
 rtl/datapath_sequencer.sv | 160 ++++++++++++++++
 tb/tb_datapath_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Micro-sequencer that fetches instructions from a small program RAM and drives datapath controls.
// Optional single-step support is compiled in with SEQ_SINGLE_STEP_EN.
module datapath_sequencer #(
    parameter int PC_W    = 6,
    parameter int INSTR_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step,
    input  logic               step_mode,
`endif
    input  logic               Flag,
    output logic [3:0]         Sel,
    output logic               Wen,
    output logic [3:0]         WA,
    output logic [3:0]         RAA,
    output logic [3:0]         RAB,
    output logic [2:0]         Op,
    output logic               busy,
    output logic               halted,
    output logic [PC_W-1:0]    pc
);

    localparam int DEPTH = 2 ** PC_W;
    localparam logic [PC_W-1:0] PC_ONE = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_BR_WAIT,
        ST_HALT
    } state_t;

    state_t state_reg, state_next;

    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [3:0]         sel_reg, sel_next;
    logic [2:0]         op_reg, op_next;
    logic               wen_reg, wen_next;
    logic [3:0]         wa_reg, wa_next;
    logic [3:0]         raa_reg, raa_next;
    logic [3:0]         rab_reg, rab_next;
    logic [INSTR_W-1:0] ir_reg;
    logic               fetch_en;
    logic               prog_en;
    logic               step_ok;
    logic [PC_W-1:0]    target;

    logic [INSTR_W-1:0] mem [0:DEPTH-1];

`ifdef SEQ_SINGLE_STEP_EN
    assign step_ok = !step_mode || step;
`else
    assign step_ok = 1'b1;
`endif

    assign prog_en = prog_we && (state_reg == ST_IDLE || state_reg == ST_HALT);
    assign target  = ir_reg[PC_W-1:0];

    // Program RAM: write port only open while stopped, registered read feeds ir.
    always_ff @(posedge clk) begin
        if (prog_en) begin
            mem[prog_addr] <= prog_wdata;
        end
        if (fetch_en) begin
            ir_reg <= mem[pc_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            sel_reg   <= '0;
            op_reg    <= '0;
            wen_reg   <= 1'b0;
            wa_reg    <= '0;
            raa_reg   <= '0;
            rab_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            sel_reg   <= sel_next;
            op_reg    <= op_next;
            wen_reg   <= wen_next;
            wa_reg    <= wa_next;
            raa_reg   <= raa_next;
            rab_reg   <= rab_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        sel_next   = sel_reg;
        op_next    = op_reg;
        wa_next    = wa_reg;
        raa_next   = raa_reg;
        rab_next   = rab_reg;
        wen_next   = 1'b0;
        fetch_en   = 1'b0;
        case (state_reg)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (step_ok) begin
                    fetch_en   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                case (ir_reg[23:22])
                    2'b00: begin
                        sel_next   = ir_reg[21:18];
                        op_next    = ir_reg[17:15];
                        wen_next   = ir_reg[14];
                        wa_next    = ir_reg[13:10];
                        raa_next   = ir_reg[9:6];
                        rab_next   = ir_reg[5:2];
                        pc_next    = pc_reg + PC_ONE;
                        state_next = ST_FETCH;
                    end
                    2'b01: begin
                        pc_next    = target;
                        state_next = ST_FETCH;
                    end
                    2'b10: state_next = ST_BR_WAIT;
                    default: state_next = ST_HALT;
                endcase
            end
            // Flag has had one full cycle to settle from the last issued op.
            ST_BR_WAIT: begin
                pc_next    = Flag ? target : pc_reg + PC_ONE;
                state_next = ST_FETCH;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign Sel    = sel_reg;
    assign Op     = op_reg;
    assign Wen    = wen_reg;
    assign WA     = wa_reg;
    assign RAA    = raa_reg;
    assign RAB    = rab_reg;
    assign pc     = pc_reg;
    assign busy   = (state_reg == ST_FETCH) || (state_reg == ST_ISSUE) || (state_reg == ST_BR_WAIT);
    assign halted = (state_reg == ST_HALT);

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: expected Wen transactions and pc traces are queued
// as programs are launched and consumed by a negedge monitor.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, prog_we, Flag;
    logic [5:0]  prog_addr;
    logic [23:0] prog_wdata;
    logic [3:0]  Sel, WA, RAA, RAB;
    logic [2:0]  Op;
    logic        Wen, busy, halted;
    logic [5:0]  pc;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step = 1'b0;
    logic        step_mode = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] sel;
        logic [2:0] op;
        logic [3:0] wa;
        logic [3:0] raa;
        logic [3:0] rab;
    } wen_t;

    wen_t       exp_q[$];
    logic [5:0] pc_q[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;

    always #5 clk = ~clk;

    datapath_sequencer #(.PC_W(6), .INSTR_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step), .step_mode(step_mode),
`endif
        .Flag(Flag), .Sel(Sel), .Wen(Wen), .WA(WA), .RAA(RAA), .RAB(RAB), .Op(Op),
        .busy(busy), .halted(halted), .pc(pc)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [23:0] alu(input logic [3:0] sel, input logic [2:0] op, input logic wen,
                                        input logic [3:0] wa, input logic [3:0] raa, input logic [3:0] rab);
        return {2'b00, sel, op, wen, wa, raa, rab, 2'b00};
    endfunction
    function automatic logic [23:0] jmp(input logic [5:0] t);
        return {2'b01, 16'd0, t};
    endfunction
    function automatic logic [23:0] brf(input logic [5:0] t);
        return {2'b10, 16'd0, t};
    endfunction
    function automatic logic [23:0] hlt();
        return {2'b11, 22'd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input logic [5:0] a, input logic [23:0] d);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 50 && !halted; i++) tick();
        check(tag, halted, 1);
    endtask

    task automatic push_wen(input logic [3:0] sel, input logic [2:0] op,
                            input logic [3:0] wa, input logic [3:0] raa, input logic [3:0] rab);
        wen_t e;
        e = '{sel: sel, op: op, wa: wa, raa: raa, rab: rab};
        exp_q.push_back(e);
    endtask

    // Monitor: every Wen cycle consumes one expected transaction; pc trace consumed while busy.
    always @(negedge clk) begin
        if (!rst) begin
            if (Wen) begin
                if (exp_q.size() == 0) begin
                    check("wen_unexpected", 32'(Wen), 0);
                end else begin
                    wen_t e;
                    e = exp_q.pop_front();
                    check("wen_sel", Sel, e.sel);
                    check("wen_op", Op, e.op);
                    check("wen_wa", WA, e.wa);
                    check("wen_raa", RAA, e.raa);
                    check("wen_rab", RAB, e.rab);
                    $display("wen txn: WA=%0d RAA=%0d RAB=%0d Op=%0d Sel=%0d", WA, RAA, RAB, Op, Sel);
                end
            end
            if (busy && pc_q.size() > 0) begin
                logic [5:0] p;
                p = pc_q.pop_front();
                check("pc_trace", pc, p);
                $display("pc txn: pc=%0d", pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; Flag = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc, 0);
        check("rst_wen", Wen, 0);
        check("rst_sel", Sel, 0);
        check("rst_op", Op, 0);
        check("rst_wa", WA, 0);
        tick();
        check("start_with_rst_ignored", busy, 0);

        // Single ALU then HALT.
        write_mem(6'd0, alu(4'd0, 3'd0, 1'b1, 4'd3, 4'd1, 4'd2));
        write_mem(6'd1, hlt());
        push_wen(4'd0, 3'd0, 4'd3, 4'd1, 4'd2);
        pulse_start();
        check("run_busy", busy, 1);
        wait_halt("alu_halt_reached");
        check("alu_busy", busy, 0);
        check("alu_pc", pc, 1);
        check("alu_q_empty", exp_q.size(), 0);
        check("alu_wa_hold", WA, 3);
        check("alu_raa_hold", RAA, 1);

        // Branch taken.
        write_mem(6'd0, brf(6'd5));
        write_mem(6'd5, hlt());
        Flag = 1'b1;
        pc_q.push_back(6'd0); pc_q.push_back(6'd0); pc_q.push_back(6'd0); pc_q.push_back(6'd5);
        pulse_start();
        wait_halt("brt_halt_reached");
        check("brt_pc", pc, 5);
        check("brt_trace_done", pc_q.size(), 0);

        // Branch not taken.
        write_mem(6'd1, hlt());
        Flag = 1'b0;
        pc_q.push_back(6'd0); pc_q.push_back(6'd0); pc_q.push_back(6'd0); pc_q.push_back(6'd1);
        pulse_start();
        wait_halt("brn_halt_reached");
        check("brn_pc", pc, 1);
        check("brn_trace_done", pc_q.size(), 0);

        // Wrap-around 63 -> 0.
        write_mem(6'd0, jmp(6'd63));
        write_mem(6'd63, alu(4'd5, 3'd3, 1'b0, 4'd7, 4'd8, 4'd9));
        pc_q.push_back(6'd0); pc_q.push_back(6'd0); pc_q.push_back(6'd63);
        pc_q.push_back(6'd63); pc_q.push_back(6'd0);
        pulse_start();
        for (int i = 0; i < 6; i++) tick();
        check("wrap_trace_done", pc_q.size(), 0);
        check("wrap_sel", Sel, 5);
        check("wrap_op", Op, 3);
        check("wrap_busy", busy, 1);
        rst = 1'b1; tick(); rst = 1'b0;

        // Infinite loop, ignored write, reset during ISSUE.
        write_mem(6'd0, alu(4'd2, 3'd5, 1'b1, 4'd9, 4'd4, 4'd6));
        write_mem(6'd1, jmp(6'd0));
        push_wen(4'd2, 3'd5, 4'd9, 4'd4, 4'd6);
        pulse_start();
        tick();
        tick();
        prog_we = 1'b1; prog_addr = 6'd0; prog_wdata = hlt();
        tick();
        prog_we = 1'b0;
        tick();
        tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("midrst_wen", Wen, 0);
        check("midrst_pc", pc, 0);
        check("midrst_busy", busy, 0);
        check("midrst_halted", halted, 0);
        check("midrst_sel", Sel, 0);
        check("midrst_q_empty", exp_q.size(), 0);

        push_wen(4'd2, 3'd5, 4'd9, 4'd4, 4'd6);
        pulse_start();
        tick();
        tick();
        tick();
        check("ignored_write_q_empty", exp_q.size(), 0);
        check("ignored_write_not_halted", halted, 0);
        check("wen_single_cycle", Wen, 0);
        rst = 1'b1; tick(); rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
